// File: rtl/exe_stage_pkg.sv
// Shared definitions for the 3-bit-opcode pipeline.
// Holds the datapath and register-address widths, the named opcode
// constants used by ID, EXE and control logic, and the EXE-stage FSM
// state type.
package exe_stage_pkg;

    localparam int DSIZE = 32;
    localparam int ASIZE = 5;

    // Width of the multiply iteration counter (counts 0 .. DSIZE-1)
    localparam int CSIZE = $clog2(DSIZE);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } exeState_e;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU for the single-cycle opcodes.
// Ports:
//   a, b    : operands (DSIZE bits)
//   opcode  : 3-bit opcode; ADD, SUB, AND, OR, XOR, SLT are computed
//   result  : DSIZE-bit result; zero for MUL/NOP, which are handled elsewhere
module alu
    import exe_stage_pkg::*;
(
    input  logic [DSIZE-1:0] a,
    input  logic [DSIZE-1:0] b,
    input  logic [2:0]       opcode,
    output logic [DSIZE-1:0] result
);

    // ADD/SUB wrap modulo 2^DSIZE; SLT is a signed compare producing 0 or 1
    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(DSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage plus EXE/WB pipeline register.
// Single-cycle ALU ops are registered every cycle. MUL is an iterative
// shift-add over DSIZE cycles that stalls upstream until the product is
// registered.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   rdata1_in  : operand A from ID/EXE
//   rdata2_in  : operand B from ID/EXE
//   opcode_in  : opcode from ID/EXE
//   waddr_in   : destination register from ID/EXE
//   stall      : combinational; IF/ID and ID/EXE hold while high
//   wdata_out  : registered result to WB
//   waddr_out  : registered destination to WB
//   wen_out    : registered write enable to WB
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] rdata1_in,
    input  logic [DSIZE-1:0] rdata2_in,
    input  logic [2:0]       opcode_in,
    input  logic [ASIZE-1:0] waddr_in,
    output logic             stall,
    output logic [DSIZE-1:0] wdata_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic             wen_out
);

    exeState_e        state_q, state_d;
    logic [CSIZE-1:0] counter_q, counter_d;
    logic [DSIZE-1:0] mcand_q, mcand_d;
    logic [DSIZE-1:0] mplier_q, mplier_d;
    logic [DSIZE-1:0] acc_q, acc_d;
    logic [ASIZE-1:0] mulWaddr_q, mulWaddr_d;
    logic [DSIZE-1:0] wdata_q, wdata_d;
    logic [ASIZE-1:0] waddr_q, waddr_d;
    logic             wen_q, wen_d;

    logic [DSIZE-1:0] aluResult;
    logic [DSIZE-1:0] mulAddend;
    logic             lastIter;

    alu uAlu (
        .a      (rdata1_in),
        .b      (rdata2_in),
        .opcode (opcode_in),
        .result (aluResult)
    );

    assign mulAddend = mplier_q[0] ? mcand_q : '0;
    assign lastIter  = (counter_q == CSIZE'(DSIZE - 1));

    // Next-state, shift-add datapath and EXE/WB next values.
    // The final iteration folds its partial product straight into the
    // written result instead of into acc, so stall can drop one cycle
    // early and upstream advances on the same edge as the writeback.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        mulWaddr_d = mulWaddr_q;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        wen_d      = wen_q;
        stall      = 1'b0;

        case (state_q)
            IDLE: begin
                waddr_d = waddr_in;
                if (opcode_in == OP_MUL) begin
                    stall      = 1'b1;
                    mcand_d    = rdata1_in;
                    mplier_d   = rdata2_in;
                    acc_d      = '0;
                    counter_d  = '0;
                    mulWaddr_d = waddr_in;
                    wdata_d    = '0;
                    wen_d      = 1'b0;
                    state_d    = BUSY;
                end else if (opcode_in == OP_NOP) begin
                    wdata_d = '0;
                    wen_d   = 1'b0;
                end else begin
                    wdata_d = aluResult;
                    wen_d   = 1'b1;
                end
            end
            BUSY: begin
                wdata_d = '0;
                wen_d   = 1'b0;
                if (lastIter) begin
                    wdata_d = acc_q + mulAddend;
                    waddr_d = mulWaddr_q;
                    wen_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall     = 1'b1;
                    acc_d     = acc_q + mulAddend;
                    mcand_d   = mcand_q << 1;
                    mplier_d  = mplier_q >> 1;
                    counter_d = counter_q + CSIZE'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Upstream must not be frozen while the pipeline is being reset
        if (rst) begin
            stall = 1'b0;
        end
    end

    // State and pipeline registers; reset aborts any multiply in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            mulWaddr_q <= '0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            wen_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            mulWaddr_q <= mulWaddr_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            wen_q      <= wen_d;
        end
    end

    assign wdata_out = wdata_q;
    assign waddr_out = waddr_q;
    assign wen_out   = wen_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed table of single-cycle ops,
// hand-written multiply and reset sequences, and randomized traffic
// compared against a plain-arithmetic reference model.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [DSIZE-1:0] rdata1_in;
    logic [DSIZE-1:0] rdata2_in;
    logic [2:0]       opcode_in;
    logic [ASIZE-1:0] waddr_in;
    logic             stall;
    logic [DSIZE-1:0] wdata_out;
    logic [ASIZE-1:0] waddr_out;
    logic             wen_out;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        logic [2:0]       op;
        logic [DSIZE-1:0] a;
        logic [DSIZE-1:0] b;
        logic [ASIZE-1:0] addr;
        logic [DSIZE-1:0] expData;
        logic             expWen;
        string            name;
    } vec_t;

    vec_t vectors[8];

    exe_stage dut (
        .clk       (clk),
        .rst       (rst),
        .rdata1_in (rdata1_in),
        .rdata2_in (rdata2_in),
        .opcode_in (opcode_in),
        .waddr_in  (waddr_in),
        .stall     (stall),
        .wdata_out (wdata_out),
        .waddr_out (waddr_out),
        .wen_out   (wen_out)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Reference result of one instruction, straight from the opcode meanings
    function automatic logic [DSIZE-1:0] refResult(input logic [2:0] op,
                                                   input logic [DSIZE-1:0] a,
                                                   input logic [DSIZE-1:0] b);
        logic [2*DSIZE-1:0] product;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
            OP_MUL: begin
                product = {{DSIZE{1'b0}}, a} * {{DSIZE{1'b0}}, b};
                return product[DSIZE-1:0];
            end
            default: return '0;
        endcase
    endfunction

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [DSIZE-1:0] actual,
                               input logic [DSIZE-1:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present one instruction from ID/EXE just after a falling edge
    task automatic applyStimulus(input logic [2:0] op, input logic [DSIZE-1:0] a,
                                 input logic [DSIZE-1:0] b, input logic [ASIZE-1:0] addr);
        @(negedge clk);
        opcode_in = op;
        rdata1_in = a;
        rdata2_in = b;
        waddr_in  = addr;
    endtask

    // One single-cycle instruction: no stall, result on the next edge
    task automatic runSingle(input string name, input logic [2:0] op,
                             input logic [DSIZE-1:0] a, input logic [DSIZE-1:0] b,
                             input logic [ASIZE-1:0] addr,
                             input logic [DSIZE-1:0] expData, input logic expWen);
        applyStimulus(op, a, b, addr);
        #1;
        checkOutput({name, " stall"}, stall, 0);
        @(posedge clk);
        #1;
        checkOutput({name, " wdata"}, wdata_out, expData);
        checkOutput({name, " waddr"}, waddr_out, addr);
        checkOutput({name, " wen"}, wen_out, expWen);
    endtask

    // One multiply held upstream while stall is high; counts stall cycles,
    // watches the bubble and checks the single writeback
    task automatic runMul(input string name, input logic [DSIZE-1:0] a,
                          input logic [DSIZE-1:0] b, input logic [ASIZE-1:0] addr);
        int   stallCycles;
        int   bubbleWrites;
        logic sawStall;
        logic done;
        stallCycles  = 0;
        bubbleWrites = 0;
        done         = 1'b0;
        applyStimulus(OP_MUL, a, b, addr);
        for (int c = 0; c < DSIZE + 8 && !done; c++) begin
            #1;
            sawStall = stall;
            if (c == 0) checkOutput({name, " issue stall"}, sawStall, 1);
            @(posedge clk);
            #1;
            if (sawStall) begin
                stallCycles++;
                if (wen_out !== 1'b0) bubbleWrites++;
            end else begin
                done = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        checkOutput({name, " completed"}, done, 1);
        checkOutput({name, " stall cycles"}, stallCycles, DSIZE);
        checkOutput({name, " bubble writes"}, bubbleWrites, 0);
        checkOutput({name, " wdata"}, wdata_out, refResult(OP_MUL, a, b));
        checkOutput({name, " waddr"}, waddr_out, addr);
        checkOutput({name, " wen"}, wen_out, 1);
    endtask

    // Global guard so a stuck run still ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int writes;
        logic [2:0]       op;
        logic [DSIZE-1:0] a;
        logic [DSIZE-1:0] b;
        logic [ASIZE-1:0] addr;

        vectors[0] = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3,  32'h0000_0000, 1'b1, "add wrap"};
        vectors[1] = '{OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5,  32'h0000_0001, 1'b1, "slt -1<1"};
        vectors[2] = '{OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 1'b1, "slt 1<-1"};
        vectors[3] = '{OP_SUB, 32'h0000_0005, 32'h0000_0007, 5'd7,  32'hFFFF_FFFE, 1'b1, "sub 5-7"};
        vectors[4] = '{OP_NOP, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4,  32'h0000_0000, 1'b0, "nop"};
        vectors[5] = '{OP_AND, 32'hF0F0_FF00, 32'h3C3C_0FF0, 5'd8,  32'h3030_0F00, 1'b1, "and"};
        vectors[6] = '{OP_OR,  32'hF0F0_0000, 32'h0F00_00FF, 5'd10, 32'hFFF0_00FF, 1'b1, "or"};
        vectors[7] = '{OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 5'd31, 32'h5555_5555, 1'b1, "xor"};

        // Reset with a MUL presented: stall must stay low under reset
        rst       = 1'b1;
        opcode_in = OP_MUL;
        rdata1_in = 32'd7;
        rdata2_in = 32'd6;
        waddr_in  = 5'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset stall", stall, 0);
        checkOutput("reset wdata", wdata_out, 0);
        checkOutput("reset waddr", waddr_out, 0);
        checkOutput("reset wen", wen_out, 0);
        opcode_in = OP_NOP;
        rst       = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runSingle(vectors[i].name, vectors[i].op, vectors[i].a, vectors[i].b,
                      vectors[i].addr, vectors[i].expData, vectors[i].expWen);
        end

        // Multiply, then a NOP to show the product is written exactly once
        runMul("mul 7*6", 32'd7, 32'd6, 5'd9);
        runSingle("nop after mul", OP_NOP, 32'd1, 32'd1, 5'd2, 32'd0, 1'b0);

        // Product overflowing the low half, then an ADD with no gap
        runMul("mul 2^16*2^16", 32'h0001_0000, 32'h0001_0000, 5'd11);
        runSingle("add after mul", OP_ADD, 32'd2, 32'd3, 5'd12, 32'd5, 1'b1);

        // Back-to-back multiplies: the second issues right after writeback
        runMul("mul 3*3", 32'd3, 32'd3, 5'd13);
        runMul("mul -1*2", 32'hFFFF_FFFF, 32'd2, 5'd14);

        // Reset while BUSY at counter 10: no partial product may be written
        applyStimulus(OP_MUL, 32'd123, 32'd456, 5'd15);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        opcode_in = OP_NOP;
        #1;
        checkOutput("rst busy stall", stall, 0);
        @(posedge clk);
        #1;
        checkOutput("rst busy wdata", wdata_out, 0);
        checkOutput("rst busy waddr", waddr_out, 0);
        checkOutput("rst busy wen", wen_out, 0);
        @(negedge clk);
        rst    = 1'b0;
        writes = 0;
        repeat (DSIZE + 4) begin
            @(posedge clk);
            #1;
            if (wen_out !== 1'b0) writes++;
        end
        checkOutput("rst busy no writeback", writes, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            a    = $urandom;
            b    = $urandom;
            addr = ASIZE'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1) b = DSIZE'($urandom_range(0, 255));
                runMul("rand mul", a, b, addr);
            end else begin
                op = 3'($urandom_range(0, 6));
                if (op == OP_MUL) op = OP_NOP;
                if ($urandom_range(0, 3) == 0) b = a;
                runSingle("rand op", op, a, b, addr, refResult(op, a, b),
                          (op != OP_NOP));
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
